// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: operation codes, FSM states,
// flag bit positions and the codop-dependent flag masking rules.
package alu_pkg;

  localparam int ALU_WIDTH   = 16;
  localparam int ALU_CODOP_W = 4;

  typedef logic [ALU_CODOP_W-1:0] codop_t;

  localparam codop_t OP_ADD   = 4'd0;
  localparam codop_t OP_SUB   = 4'd1;
  localparam codop_t OP_GT    = 4'd2;
  localparam codop_t OP_AND   = 4'd3;
  localparam codop_t OP_OR    = 4'd4;
  localparam codop_t OP_XOR   = 4'd5;
  localparam codop_t OP_NOT   = 4'd6;
  localparam codop_t OP_SLL   = 4'd7;
  localparam codop_t OP_SRL   = 4'd8;
  localparam codop_t OP_INC   = 4'd9;
  localparam codop_t OP_DEC   = 4'd10;
  localparam codop_t OP_LT    = 4'd11;
  localparam codop_t OP_MOVZ  = 4'd12;
  localparam codop_t OP_MFH   = 4'd13;
  localparam codop_t OP_MFL   = 4'd14;
  localparam codop_t OP_UNDEF = 4'd15;

  // Response flag vector is {neg, zero, overflow}
  localparam int FLAG_OVF  = 0;
  localparam int FLAG_ZERO = 1;
  localparam int FLAG_NEG  = 2;
  localparam int FLAG_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  // Sign and overflow are only meaningful for the arithmetic operations
  function automatic logic has_arith_flags(input codop_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_INC) || (op == OP_DEC);
  endfunction

  function automatic logic has_zero_flag(input codop_t op);
    return (op == OP_MOVZ);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; on a tie the requester that did not win
// last time is granted. last_grant resets to B so that A wins the first tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    grant_o      = 2'b00;
    last_grant_d = last_grant_q;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_grant_q ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
    if (advance_i && (grant_o != 2'b00)) begin
      last_grant_d = grant_o[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between requesters A and B: one operation in
// flight, round-robin grant, registered ALU drive and per-requester responses.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int CODOP_W = ALU_CODOP_W
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               a_req_valid,
  output logic               a_req_ready,
  input  logic [CODOP_W-1:0] a_req_codop,
  input  logic [WIDTH-1:0]   a_req_op1,
  input  logic [WIDTH-1:0]   a_req_op2,
  output logic               a_rsp_valid,
  input  logic               a_rsp_ready,
  output logic [WIDTH-1:0]   a_rsp_result,
  output logic [2:0]         a_rsp_flags,

  input  logic               b_req_valid,
  output logic               b_req_ready,
  input  logic [CODOP_W-1:0] b_req_codop,
  input  logic [WIDTH-1:0]   b_req_op1,
  input  logic [WIDTH-1:0]   b_req_op2,
  output logic               b_rsp_valid,
  input  logic               b_rsp_ready,
  output logic [WIDTH-1:0]   b_rsp_result,
  output logic [2:0]         b_rsp_flags,

  output logic [CODOP_W-1:0] alu_codop,
  output logic [WIDTH-1:0]   alu_op1,
  output logic [WIDTH-1:0]   alu_op2,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_neg,
  input  logic               alu_zero,
  input  logic               alu_ovf
);

  state_e state_q, state_d;

  logic [CODOP_W-1:0] codop_q, codop_d;
  logic [WIDTH-1:0]   op1_q, op1_d;
  logic [WIDTH-1:0]   op2_q, op2_d;
  logic               owner_q, owner_d;

  // Index 0 belongs to requester A, index 1 to requester B
  logic [1:0]                   rsp_valid_q, rsp_valid_d;
  logic [1:0][WIDTH-1:0]        rsp_result_q, rsp_result_d;
  logic [1:0][FLAG_W-1:0]       rsp_flags_q, rsp_flags_d;

  logic [1:0]        arb_req;
  logic [1:0]        grant;
  logic              in_idle;
  logic [1:0]        rsp_ready;
  logic [WIDTH-1:0]  fixed_result;
  logic [FLAG_W-1:0] masked_flags;

  assign in_idle   = (state_q == ST_IDLE);
  assign arb_req   = in_idle ? {b_req_valid, a_req_valid} : 2'b00;
  assign rsp_ready = {b_rsp_ready, a_rsp_ready};

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (arb_req),
    .advance_i (in_idle),
    .grant_o   (grant)
  );

  assign a_req_ready = grant[0];
  assign b_req_ready = grant[1];

  // Clean up ALU outputs whose value is undefined for the current operation
  always_comb begin
    fixed_result = alu_result;
    masked_flags = '0;
    if (has_arith_flags(codop_q)) begin
      masked_flags[FLAG_NEG] = alu_neg;
      masked_flags[FLAG_OVF] = alu_ovf;
    end
    if (has_zero_flag(codop_q)) begin
      masked_flags[FLAG_ZERO] = alu_zero;
    end
    if ((codop_q == OP_MOVZ) && (op1_q != '0)) begin
      fixed_result = '0;
    end
    if (codop_q == OP_UNDEF) begin
      fixed_result = '0;
      masked_flags = '0;
    end
  end

  always_comb begin
    state_d      = state_q;
    codop_d      = codop_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    owner_d      = owner_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;

    case (state_q)
      ST_IDLE: begin
        if (grant[1]) begin
          codop_d = b_req_codop;
          op1_d   = b_req_op1;
          op2_d   = b_req_op2;
          owner_d = 1'b1;
          state_d = ST_ISSUE;
        end else if (grant[0]) begin
          codop_d = a_req_codop;
          op1_d   = a_req_op1;
          op2_d   = a_req_op2;
          owner_d = 1'b0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        rsp_result_d[owner_q] = fixed_result;
        rsp_flags_d[owner_q]  = masked_flags;
        rsp_valid_d[owner_q]  = 1'b1;
        state_d               = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready[owner_q]) begin
          rsp_valid_d[owner_q] = 1'b0;
          state_d              = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      codop_q      <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      owner_q      <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      codop_q      <= codop_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      owner_q      <= owner_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  assign alu_codop    = codop_q;
  assign alu_op1      = op1_q;
  assign alu_op2      = op2_q;

  assign a_rsp_valid  = rsp_valid_q[0];
  assign a_rsp_result = rsp_result_q[0];
  assign a_rsp_flags  = rsp_flags_q[0];
  assign b_rsp_valid  = rsp_valid_q[1];
  assign b_rsp_result = rsp_result_q[1];
  assign b_rsp_flags  = rsp_flags_q[1];

endmodule
